ram_access_scheduler: RTL

//  Top-level mode controller for the image-processing core. Turns the three board activation inputs
//  (PC_RAM_ACT, PROCESS_ACT, RAM_PC_ACT) into one exclusive mode at a time and owns the shared image RAM.

---
 rtl/ram_access_scheduler.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/ram_access_scheduler.sv
// ram_access_scheduler: exclusive LOAD/PROC/DUMP mode controller owning the image RAM; define SCHED_DEBOUNCE_EN to debounce the ACT inputs
`timescale 1ns/1ps
module ram_access_scheduler #(
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 8,
    parameter int IMG_WORDS = 65536,
    parameter int DEB_CYC   = 1000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              PC_RAM_ACT,
    input  logic              PROCESS_ACT,
    input  logic              RAM_PC_ACT,
    input  logic              rx_valid,
    input  logic [DATA_W-1:0] rx_data,
    input  logic              tx_busy,
    output logic              tx_start,
    output logic [DATA_W-1:0] tx_data,
    output logic              proc_start,
    input  logic              proc_done,
    output logic              proc_grant,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    output logic              ram_we,
    input  logic [DATA_W-1:0] ram_dout,
    output logic [2:0]        mode,
    output logic              done
);
    typedef enum logic [2:0] {IDLE, LOAD, PROC_GO, PROC_WAIT, DUMP_RD, DUMP_CAP, DUMP_TX, DUMP_ACK} state_t;
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(IMG_WORDS - 1);

    if (DEB_CYC < 1 || IMG_WORDS < 1 || IMG_WORDS > 2 ** ADDR_W) begin : g_bad_cfg
        $error("ram_access_scheduler: bad parameter set");
    end

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d, ram_addr_q, ram_addr_d, addr_nx;
    logic [DATA_W-1:0] ram_din_q, ram_din_d, tx_data_q, tx_data_d;
    logic              ram_we_q, ram_we_d, tx_start_q, tx_start_d, proc_start_q, proc_start_d;
    logic              proc_grant_q, proc_grant_d, done_q, done_d, skip_q, skip_d, last;
    logic [2:0]        sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d, filt, req;

`ifdef SCHED_DEBOUNCE_EN
    localparam int CW = $clog2(DEB_CYC + 1);
    logic [2:0][CW-1:0] cnt_q, cnt_d;
    logic [2:0]         filt_q, filt_d;
    always_comb begin
        cnt_d  = cnt_q;
        filt_d = filt_q;
        for (int i = 0; i < 3; i++) begin
            filt_d[i] = (sync2_q[i] != filt_q[i] && cnt_q[i] == CW'(DEB_CYC - 1)) ? sync2_q[i] : filt_q[i];
            cnt_d[i]  = (sync2_q[i] == filt_q[i] || cnt_q[i] == CW'(DEB_CYC - 1)) ? '0 : cnt_q[i] + 1'b1;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            filt_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            filt_q <= filt_d;
        end
    end
    assign filt = filt_q;
`else
    assign filt = sync2_q;
`endif

    assign req     = filt & ~prev_q;
    assign last    = addr_q == LAST;
    assign addr_nx = last ? '0 : addr_q + 1'b1;

    always_comb begin
        sync1_d      = {RAM_PC_ACT, PROCESS_ACT, PC_RAM_ACT};
        sync2_d      = sync1_q;
        prev_d       = filt;
        state_d      = state_q;
        addr_d       = addr_q;
        ram_addr_d   = ram_addr_q;
        ram_din_d    = ram_din_q;
        tx_data_d    = tx_data_q;
        proc_grant_d = proc_grant_q;
        ram_we_d     = 1'b0;
        tx_start_d   = 1'b0;
        proc_start_d = 1'b0;
        done_d       = 1'b0;
        skip_d       = 1'b0;
        case (state_q)
            IDLE: begin
                addr_d = '0;
                if (req[0]) begin
                    state_d = LOAD;
                end else if (req[1]) begin
                    state_d      = PROC_GO;
                    proc_start_d = 1'b1;
                    proc_grant_d = 1'b1;
                end else if (req[2]) begin
                    state_d    = DUMP_RD;
                    ram_addr_d = '0;
                end
            end
            LOAD: if (rx_valid) begin
                ram_we_d   = 1'b1;
                ram_din_d  = rx_data;
                ram_addr_d = addr_q;
                addr_d     = addr_nx;
                done_d     = last;
                state_d    = last ? IDLE : LOAD;
            end
            PROC_GO:   state_d = PROC_WAIT;
            PROC_WAIT: if (proc_done) begin
                state_d      = IDLE;
                proc_grant_d = 1'b0;
                done_d       = 1'b1;
            end
            DUMP_RD:   state_d = DUMP_CAP;
            DUMP_CAP: begin
                tx_data_d = ram_dout;
                state_d   = DUMP_TX;
            end
            DUMP_TX: if (!tx_busy) begin
                tx_start_d = 1'b1;
                skip_d     = 1'b1;
                state_d    = DUMP_ACK;
            end
            DUMP_ACK: if (!skip_q && !tx_busy) begin
                addr_d     = addr_nx;
                ram_addr_d = addr_nx;
                done_d     = last;
                state_d    = last ? IDLE : DUMP_RD;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            ram_addr_q   <= '0;
            ram_din_q    <= '0;
            tx_data_q    <= '0;
            ram_we_q     <= 1'b0;
            tx_start_q   <= 1'b0;
            proc_start_q <= 1'b0;
            proc_grant_q <= 1'b0;
            done_q       <= 1'b0;
            skip_q       <= 1'b0;
            sync1_q      <= '0;
            sync2_q      <= '0;
            prev_q       <= '0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            ram_addr_q   <= ram_addr_d;
            ram_din_q    <= ram_din_d;
            tx_data_q    <= tx_data_d;
            ram_we_q     <= ram_we_d;
            tx_start_q   <= tx_start_d;
            proc_start_q <= proc_start_d;
            proc_grant_q <= proc_grant_d;
            done_q       <= done_d;
            skip_q       <= skip_d;
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            prev_q       <= prev_d;
        end
    end

    assign tx_start   = tx_start_q;
    assign tx_data    = tx_data_q;
    assign proc_start = proc_start_q;
    assign proc_grant = proc_grant_q;
    assign ram_addr   = ram_addr_q;
    assign ram_din    = ram_din_q;
    assign ram_we     = ram_we_q;
    assign mode       = state_q;
    assign done       = done_q;
endmodule
